multi_clock_divider: RTL and testbench

Parametrised, multi-channel clock divider and tick generator. Each channel divides `clock_in` by a runtime-programmable divisor with programmable high time and produces a divided level plus a one-cycle period-start tick. It is the general replacement for single fixed-divisor dividers and feeds slow logic such as blinkers, scanners and debouncers from the FPGA board clock. Divisor changes are glitch-free: they are held in a shadow register and take effect only at a period boundary.

---
 rtl/multi_clock_divider_pkg.sv | 15 +
 rtl/clock_divider_channel.sv | 85 ++++++++
 rtl/multi_clock_divider.sv | 38 +++
 tb/tb_multi_clock_divider.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_clock_divider_pkg.sv
// Shared types, constants and the divisor clamp for the multi-channel clock divider.
package multi_clock_divider_pkg;

   localparam int DIV_W       = 28;
   localparam int MIN_DIVISOR = 2;

   typedef logic [DIV_W-1:0] div_t;
   typedef logic [63:0]      wide_t;

   // Wide argument so channels of any WIDTH up to 64 can share one clamp.
   function automatic wide_t clamp_divisor(input wide_t d);
      return (d < wide_t'(MIN_DIVISOR)) ? wide_t'(MIN_DIVISOR) : d;
   endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, shadow/active divisor, registered level and tick.
// MULTI_CLOCK_DIVIDER_DUTY_EN adds a programmable high time; otherwise high = divisor>>1.
module clock_divider_channel
   import multi_clock_divider_pkg::*;
#(
   parameter int WIDTH           = 28,
   parameter int DEFAULT_DIVISOR = 100000000
) (
   input  logic             clock_in,
   input  logic             reset,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] divisor_in,
   input  logic [WIDTH-1:0] high_in,
   output logic             clock_out,
   output logic             tick,
   output logic             pending
);

   localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIVISOR);

   logic [WIDTH-1:0] counter;
   logic [WIDTH-1:0] active_div;
   logic [WIDTH-1:0] shadow_div;
   logic [WIDTH-1:0] active_high;
   logic [WIDTH-1:0] wr_div;
   logic             wrap;

   assign wr_div = WIDTH'(clamp_divisor(64'(divisor_in)));
   assign wrap   = (counter == active_div - WIDTH'(1));

`ifdef MULTI_CLOCK_DIVIDER_DUTY_EN
   logic [WIDTH-1:0] shadow_high;

   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         active_high <= RESET_DIV >> 1;
         shadow_high <= RESET_DIV >> 1;
      end else if (enable) begin
         if (wrap && pending) active_high <= shadow_high;
         if (load)            shadow_high <= high_in;
      end else if (load) begin
         active_high <= high_in;
         shadow_high <= high_in;
      end
   end
`else
   logic unused_high;
   assign unused_high = ^high_in;
   assign active_high = active_div >> 1;
`endif

   // A load landing on a pending wrap is ordered after the swap, so it stays pending.
   always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
         counter    <= '0;
         active_div <= RESET_DIV;
         shadow_div <= RESET_DIV;
         pending    <= 1'b0;
         clock_out  <= 1'b0;
         tick       <= 1'b0;
      end else if (enable) begin
         counter   <= wrap ? '0 : counter + WIDTH'(1);
         clock_out <= (counter < active_high);
         tick      <= wrap;
         if (wrap && pending) begin
            active_div <= shadow_div;
            pending    <= 1'b0;
         end
         if (load) begin
            shadow_div <= wr_div;
            pending    <= 1'b1;
         end
      end else begin
         tick <= 1'b0;
         if (load) begin
            active_div <= wr_div;
            shadow_div <= wr_div;
            counter    <= '0;
            pending    <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/multi_clock_divider.sv
// Multi-channel clock divider / tick generator; one clock_divider_channel per channel.
// Optional duty-cycle control via MULTI_CLOCK_DIVIDER_DUTY_EN.
module multi_clock_divider
   import multi_clock_divider_pkg::*;
#(
   parameter int CHANNELS        = 4,
   parameter int WIDTH           = 28,
   parameter int DEFAULT_DIVISOR = 100000000
) (
   input  logic                clock_in,
   input  logic                reset,
   input  logic [CHANNELS-1:0] enable,
   input  logic [CHANNELS-1:0] load,
   input  logic [WIDTH-1:0]    divisor_in,
   input  logic [WIDTH-1:0]    high_in,
   output logic [CHANNELS-1:0] clock_out,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] pending
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      clock_divider_channel #(
         .WIDTH           (WIDTH),
         .DEFAULT_DIVISOR (DEFAULT_DIVISOR)
      ) u_channel (
         .clock_in   (clock_in),
         .reset      (reset),
         .enable     (enable[i]),
         .load       (load[i]),
         .divisor_in (divisor_in),
         .high_in    (high_in),
         .clock_out  (clock_out[i]),
         .tick       (tick[i]),
         .pending    (pending[i])
      );
   end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider: directed table, corner sequences, random vs model.
module tb_multi_clock_divider;

   localparam int CH  = 2;
   localparam int W   = 8;
   localparam int DEF = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic [CH-1:0] en;
   logic [CH-1:0] ld;
   logic [W-1:0]  div_in;
   logic [W-1:0]  high_in;
   logic [CH-1:0] co;
   logic [CH-1:0] tk;
   logic [CH-1:0] pd;

   always #5 clk = ~clk;

   multi_clock_divider #(
      .CHANNELS        (CH),
      .WIDTH           (W),
      .DEFAULT_DIVISOR (DEF)
   ) dut (
      .clock_in   (clk),
      .reset      (rst),
      .enable     (en),
      .load       (ld),
      .divisor_in (div_in),
      .high_in    (high_in),
      .clock_out  (co),
      .tick       (tk),
      .pending    (pd)
   );

   typedef struct {
      int cnt; int div; int high; int sdiv; int shigh;
      bit pend; bit co; bit tk;
   } mch_t;

   typedef struct {
      bit en; bit ld; int div; bit eco; bit etk; bit epd;
   } vec_t;

   mch_t m [CH];
   vec_t tbl [25];
   int checks   = 0;
   int failures = 0;

   function automatic int clampd(int d);
      return (d < 2) ? 2 : d;
   endfunction

   function automatic int wr_high(int d, int h);
`ifdef MULTI_CLOCK_DIVIDER_DUTY_EN
      return h;
`else
      return clampd(d) / 2;
`endif
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < CH; i++) begin
         m[i].cnt = 0; m[i].div = DEF; m[i].sdiv = DEF;
         m[i].high = DEF / 2; m[i].shigh = DEF / 2;
         m[i].pend = 0; m[i].co = 0; m[i].tk = 0;
      end
   endtask

   // Period position advances on enabled cycles; new settings land at the period boundary.
   task automatic model_step();
      for (int i = 0; i < CH; i++) begin
         mch_t s, n;
         bit   last;
         s = m[i];
         n = s;
         last = (s.cnt == s.div - 1);
         if (en[i]) begin
            n.cnt = last ? 0 : s.cnt + 1;
            n.co  = (s.cnt < s.high);
            n.tk  = last;
            if (last && s.pend) begin
               n.div = s.sdiv; n.high = s.shigh; n.pend = 0;
            end
            if (ld[i]) begin
               n.sdiv = clampd(int'(div_in)); n.shigh = wr_high(int'(div_in), int'(high_in));
               n.pend = 1;
            end
         end else begin
            n.tk = 0;
            if (ld[i]) begin
               n.div  = clampd(int'(div_in)); n.sdiv = n.div;
               n.high = wr_high(int'(div_in), int'(high_in)); n.shigh = n.high;
               n.cnt  = 0; n.pend = 0;
            end
         end
         m[i] = n;
      end
   endtask

   task automatic cmp_model();
      for (int i = 0; i < CH; i++) begin
         check($sformatf("model_clock_out[%0d]", i), int'(co[i]), int'(m[i].co));
         check($sformatf("model_tick[%0d]", i),      int'(tk[i]), int'(m[i].tk));
         check($sformatf("model_pending[%0d]", i),   int'(pd[i]), int'(m[i].pend));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      cmp_model();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      #2;
      rst = 1'b0;
   endtask

   initial begin
      tbl = '{
         '{1,0,0, 1,0,0}, '{1,0,0, 1,0,0}, '{1,0,0, 1,0,0}, '{1,0,0, 1,0,0}, '{1,0,0, 1,0,0},
         '{1,0,0, 0,0,0}, '{1,0,0, 0,0,0}, '{1,0,0, 0,0,0}, '{1,0,0, 0,0,0}, '{1,0,0, 0,1,0},
         '{1,0,0, 1,0,0}, '{1,0,0, 1,0,0}, '{1,0,0, 1,0,0}, '{1,1,4, 1,0,1}, '{1,0,0, 1,0,1},
         '{1,0,0, 0,0,1}, '{1,0,0, 0,0,1}, '{1,0,0, 0,0,1}, '{1,0,0, 0,0,1}, '{1,0,0, 0,1,0},
         '{1,0,0, 1,0,0}, '{1,0,0, 1,0,0}, '{1,0,0, 0,0,0}, '{1,0,0, 0,1,0}, '{1,0,0, 1,0,0}
      };
      rst = 1'b1; en = '0; ld = '0; div_in = '0; high_in = 8'd2;
      model_reset();
      #12;
      rst = 1'b0;
      check("reset_clock_out", int'(co), 0);
      check("reset_tick",      int'(tk), 0);
      check("reset_pending",   int'(pd), 0);

      // Default period, then a mid-period divisor change to 4.
      for (int k = 0; k < 25; k++) begin
         en[0] = tbl[k].en; ld[0] = tbl[k].ld; div_in = W'(tbl[k].div);
         step();
         ld = '0;
         check($sformatf("tbl%0d_clock_out", k), int'(co[0]), int'(tbl[k].eco));
         check($sformatf("tbl%0d_tick", k),      int'(tk[0]), int'(tbl[k].etk));
         check($sformatf("tbl%0d_pending", k),   int'(pd[0]), int'(tbl[k].epd));
      end

      // Divisor 1 clamps to 2.
      en[0] = 1'b0; ld[0] = 1'b1; div_in = 8'd1; high_in = 8'd1;
      step();
      ld = '0; en[0] = 1'b1;
      for (int j = 0; j < 6; j++) begin
         step();
         check($sformatf("clamp%0d_clock_out", j), int'(co[0]), (j % 2 == 0) ? 1 : 0);
         check($sformatf("clamp%0d_tick", j),      int'(tk[0]), (j % 2 == 1) ? 1 : 0);
      end

      // Enable drop holds outputs and resumes from the held count.
      en[0] = 1'b0; ld[0] = 1'b1; div_in = 8'd10; high_in = 8'd5;
      step();
      ld = '0; en[0] = 1'b1;
      for (int j = 0; j < 4; j++) step();
      en[0] = 1'b0;
      for (int j = 0; j < 3; j++) begin
         step();
         check($sformatf("hold%0d_clock_out", j), int'(co[0]), 1);
         check($sformatf("hold%0d_tick", j),      int'(tk[0]), 0);
      end
      en[0] = 1'b1;
      for (int j = 0; j < 6; j++) begin
         step();
         check($sformatf("resume%0d_tick", j), int'(tk[0]), (j == 5) ? 1 : 0);
      end

      // Asynchronous reset mid-period with a pending write.
      for (int j = 0; j < 3; j++) begin
         ld[0] = (j == 2); div_in = 8'd6; high_in = 8'd3;
         step();
      end
      ld = '0;
      check("pre_reset_pending", int'(pd[0]), 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_clock_out", int'(co), 0);
      check("async_reset_tick",      int'(tk), 0);
      check("async_reset_pending",   int'(pd), 0);
      model_reset();
      #2;
      rst = 1'b0;

      // Channel 1 reprogrammed while channel 0 keeps its default timing.
      en = 2'b11;
      for (int k = 0; k < 30; k++) begin
         ld[1] = (k == 3 || k == 7 || k == 15); div_in = W'(3 + k % 4); high_in = 8'd1;
         step();
         ld = '0;
         check($sformatf("indep%0d_clock_out0", k), int'(co[0]), (k % 10 < 5) ? 1 : 0);
         check($sformatf("indep%0d_tick0", k),      int'(tk[0]), (k % 10 == 9) ? 1 : 0);
      end

`ifdef MULTI_CLOCK_DIVIDER_DUTY_EN
      // Programmable high time: 2 of 8, then 0 of 8.
      en[0] = 1'b0; ld[0] = 1'b1; div_in = 8'd8; high_in = 8'd2;
      step();
      ld = '0; en[0] = 1'b1;
      for (int j = 0; j < 16; j++) begin
         step();
         check($sformatf("duty2_%0d_clock_out", j), int'(co[0]), (j % 8 < 2) ? 1 : 0);
         check($sformatf("duty2_%0d_tick", j),      int'(tk[0]), (j % 8 == 7) ? 1 : 0);
      end
      en[0] = 1'b0; ld[0] = 1'b1; div_in = 8'd8; high_in = 8'd0;
      step();
      ld = '0; en[0] = 1'b1;
      for (int j = 0; j < 16; j++) begin
         step();
         check($sformatf("duty0_%0d_clock_out", j), int'(co[0]), 0);
         check($sformatf("duty0_%0d_tick", j),      int'(tk[0]), (j % 8 == 7) ? 1 : 0);
      end
`endif

      // Random enables and loads against the model.
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < CH; i++) begin
            en[i] = ($urandom_range(0, 7) != 0);
            ld[i] = ($urandom_range(0, 11) == 0);
         end
         div_in  = W'($urandom_range(0, 12));
         high_in = W'($urandom_range(0, 14));
         step();
      end
      ld = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
